// File: rtl/karatsuba_mul_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
package karatsuba_mul_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OPW   = 16;
    localparam int PRODW = 32;

endpackage

// File: rtl/karatsuba_16.sv
// 16x16 -> 32 unsigned multiplier built from three 8/9-bit partial products.
module karatsuba_16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] p
);

    logic [7:0]  xh, xl, yh, yl;
    logic [15:0] hh, ll;
    logic [8:0]  xs, ys;
    logic [17:0] mm, mid;

    assign xh = x[15:8];
    assign xl = x[7:0];
    assign yh = y[15:8];
    assign yl = y[7:0];

    assign hh = {8'b0, xh} * {8'b0, yh};
    assign ll = {8'b0, xl} * {8'b0, yl};
    assign xs = {1'b0, xh} + {1'b0, xl};
    assign ys = {1'b0, yh} + {1'b0, yl};
    assign mm = {9'b0, xs} * {9'b0, ys};

    // Cross term xh*yl + xl*yh recovered without a fourth multiply.
    assign mid = mm - {2'b0, hh} - {2'b0, ll};

    assign p = {hh, ll} + {6'b0, mid, 8'b0};

endmodule

// File: rtl/karatsuba_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or above rr_ptr, wrapping.
import karatsuba_mul_arbiter_pkg::*;

module mul_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_req
);

    logic [ID_W:0] pos;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
            if (!found && req[pos[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = pos[ID_W-1:0];
            end
        end
        if (enable && found) gnt[gnt_idx] = 1'b1;
    end

    assign any_req = |req;

endmodule

// File: rtl/rca_Nbit.sv
// N-bit ripple-carry adder; only needed by the KARATSUBA_MUL_ARBITER_SIGNED_EN build.
`ifdef KARATSUBA_MUL_ARBITER_SIGNED_EN
module rca_Nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic [N-1:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule
`endif

// File: rtl/karatsuba_mul_arbiter.sv
// Round-robin sharing of one registered karatsuba_16 among NUM_REQ requesters.
// Define KARATSUBA_MUL_ARBITER_SIGNED_EN to add per-request two's-complement mode.
import karatsuba_mul_arbiter_pkg::*;

module karatsuba_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [OPW*NUM_REQ-1:0] req_x,
    input  logic [OPW*NUM_REQ-1:0] req_y,
`ifdef KARATSUBA_MUL_ARBITER_SIGNED_EN
    input  logic [NUM_REQ-1:0]     req_signed,
`endif
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [PRODW-1:0]       resp_prod,
    output logic                   busy
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, id_q, gnt_idx;
    logic             any_req, arb_en, xfer;
    logic [OPW-1:0]   sel_x, sel_y, op_x_nxt, op_y_nxt;
    logic [OPW-1:0]   op_x, op_y;
    logic [PRODW-1:0] mul_p, prod_nxt, prod_q;

    // A new request may only be taken while the result slot is free or being drained.
    assign arb_en = (state == IDLE) || ((state == RESP) && resp_ready);

    mul_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .enable  (arb_en),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign xfer  = arb_en && any_req;
    assign sel_x = req_x[gnt_idx*OPW +: OPW];
    assign sel_y = req_y[gnt_idx*OPW +: OPW];

    karatsuba_16 u_mul (
        .x (op_x),
        .y (op_y),
        .p (mul_p)
    );

`ifdef KARATSUBA_MUL_ARBITER_SIGNED_EN
    logic             sel_signed, sign_nxt, sign_q;
    logic [PRODW-1:0] prod_neg;

    assign sel_signed = req_signed[gnt_idx];
    // Magnitudes are stored; -32768 maps to 0x8000, which the unsigned core handles.
    assign op_x_nxt = (sel_signed && sel_x[OPW-1]) ? (~sel_x + 16'd1) : sel_x;
    assign op_y_nxt = (sel_signed && sel_y[OPW-1]) ? (~sel_y + 16'd1) : sel_y;
    assign sign_nxt = sel_signed && (sel_x[OPW-1] ^ sel_y[OPW-1]);

    rca_Nbit #(
        .N (PRODW)
    ) u_neg (
        .a   (~mul_p),
        .b   ({PRODW{1'b0}}),
        .cin (1'b1),
        .sum (prod_neg)
    );

    assign prod_nxt = sign_q ? prod_neg : mul_p;
`else
    assign op_x_nxt = sel_x;
    assign op_y_nxt = sel_y;
    assign prod_nxt = mul_p;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = MUL;
            MUL:     state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = xfer ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            id_q   <= '0;
            op_x   <= '0;
            op_y   <= '0;
            prod_q <= '0;
`ifdef KARATSUBA_MUL_ARBITER_SIGNED_EN
            sign_q <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                op_x   <= op_x_nxt;
                op_y   <= op_y_nxt;
                id_q   <= gnt_idx;
                rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
`ifdef KARATSUBA_MUL_ARBITER_SIGNED_EN
                sign_q <= sign_nxt;
`endif
            end
            // Operand registers -> product register: the multiplier gets a full cycle.
            if (state == MUL) prod_q <= prod_nxt;
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_id    = id_q;
    assign resp_prod  = prod_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Bench for karatsuba_mul_arbiter: cycle model + scoreboard, vector table, corner sequences.
module tb_karatsuba_mul_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_x, req_y;
    logic [3:0]  req_signed;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_id;
    logic [31:0] resp_prod;
    logic        busy;

    karatsuba_mul_arbiter #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
`ifdef KARATSUBA_MUL_ARBITER_SIGNED_EN
        .req_signed (req_signed),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y, input logic s);
        longint a, b;
        if (s) begin
            a = longint'($signed(x));
            b = longint'($signed(y));
        end else begin
            a = longint'(x);
            b = longint'(y);
        end
        return 32'(a * b);
    endfunction

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] i;
            i = 2'(ptr + k);
            if (v[i]) return int'(i);
        end
        return -1;
    endfunction

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] prod;
    } sb_t;

    sb_t         sb[$];
    logic [1:0]  dut_ids[$];
    logic [31:0] dut_prods[$];
    int          dut_cyc[$];
    int          m_state = 0;
    int          m_ptr   = 0;
    int          cyc     = 0;

    // Cycle model: predicts grant/state, pushes on accept, pops on response handshake.
    always @(negedge clk) begin : mon
        logic       en;
        int         g;
        logic [3:0] exp_rdy;
        sb_t        e;
        cyc++;
        en = (m_state == 0) || ((m_state == 2) && resp_ready);
        g  = pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (en && g >= 0) exp_rdy[2'(g)] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(m_state == 2));
        chk("busy", 32'(busy), 32'(m_state != 0));
        if (resp_valid && resp_ready) begin
            dut_ids.push_back(resp_id);
            dut_prods.push_back(resp_prod);
            dut_cyc.push_back(cyc);
        end
        if (m_state == 2) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_underflow: actual=response expected=no_pending");
            end else begin
                chk("resp_id", 32'(resp_id), 32'(sb[0].id));
                chk("resp_prod", resp_prod, sb[0].prod);
                if (resp_ready) void'(sb.pop_front());
            end
        end
        if (!rst_n) begin
            m_state = 0;
            m_ptr   = 0;
            sb.delete();
        end else begin
            if (en && g >= 0) begin
                e.id   = 2'(g);
                e.prod = ref_prod(req_x[g*16 +: 16], req_y[g*16 +: 16], req_signed[2'(g)]);
                sb.push_back(e);
                m_ptr = (g + 1) % 4;
            end
            case (m_state)
                0:       m_state = (en && g >= 0) ? 1 : 0;
                1:       m_state = 2;
                default: if (resp_ready) m_state = (g >= 0) ? 1 : 0;
            endcase
        end
    end

    task automatic do_op(input int r, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic [31:0] exp, input string name);
        logic acc, found;
        int   lat;
        acc = 1'b0;
        found = 1'b0;
        lat = 0;
        resp_ready = 1'b1;
        req_x[r*16 +: 16] = x;
        req_y[r*16 +: 16] = y;
        req_signed[r] = s;
        req_valid = 4'(1 << r);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready[r];
        end
        @(posedge clk); #1;
        req_valid = '0;
        req_signed[r] = 1'b0;
        chk({name, "_accept"}, 32'(acc), 32'd1);
        if (!acc) return;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                found = 1'b1;
                lat = i;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'd2);
        chk({name, "_prod"}, resp_prod, exp);
        chk({name, "_id"}, 32'(resp_id), 32'(r));
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          r;
        logic [15:0] x;
        logic [15:0] y;
        logic        s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic        acc, found;
        logic [1:0]  exp_ids[5];
        logic [31:0] exp_prods[4];

        vecs.push_back('{0, 16'h0000, 16'hFFFF, 1'b0, 32'h00000000});
        vecs.push_back('{1, 16'h0001, 16'hABCD, 1'b0, 32'h0000ABCD});
        vecs.push_back('{2, 16'h8000, 16'h8000, 1'b0, 32'h40000000});
        vecs.push_back('{3, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
        vecs.push_back('{0, 16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE});
        vecs.push_back('{1, 16'h8000, 16'h0001, 1'b0, 32'h00008000});
        vecs.push_back('{2, 16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF});
`ifdef KARATSUBA_MUL_ARBITER_SIGNED_EN
        vecs.push_back('{0, 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE});
        vecs.push_back('{1, 16'h8000, 16'h8000, 1'b1, 32'h40000000});
        vecs.push_back('{2, 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000});
        vecs.push_back('{3, 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000});
`endif

        rst_n = 1'b0;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        req_signed = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_prod", resp_prod, 32'd0);
        @(posedge clk); #1;

        do_op(2, 16'h1234, 16'h5678, 1'b0, 32'h06260060, "single_r2");

        // Reset while the request is in MUL: it must vanish.
        acc = 1'b0;
        req_x[16 +: 16] = 16'h00AA;
        req_y[16 +: 16] = 16'h0055;
        req_valid = 4'b0010;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready[1];
        end
        chk("midrst_accept", 32'(acc), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy_in_mul", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
            chk("midrst_idle", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;

        // All requesters valid: rotation from pointer 0, one result every 2 cycles.
        dut_ids.delete();
        dut_prods.delete();
        dut_cyc.delete();
        req_x = {16'h00FF, 16'h1234, 16'h0003, 16'hFFFF};
        req_y = {16'h0100, 16'h5678, 16'h0007, 16'hFFFF};
        req_valid = 4'hF;
        repeat (11) @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_prods = '{32'hFFFE0001, 32'h00000015, 32'h06260060, 32'h0000FF00};
        chk("rot_count_ok", 32'(dut_ids.size() >= 5), 32'd1);
        if (dut_ids.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("rot_id%0d", k), 32'(dut_ids[k]), 32'(exp_ids[k]));
            for (int k = 0; k < 4; k++) chk($sformatf("rot_prod%0d", k), dut_prods[k], exp_prods[k]);
            for (int k = 0; k < 4; k++) chk($sformatf("rot_gap%0d", k), 32'(dut_cyc[k+1] - dut_cyc[k]), 32'd2);
        end

        // Consumer stall: requester 3 wins (pointer at 2), output holds, nothing granted.
        resp_ready = 1'b0;
        req_valid = 4'b1001;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = resp_valid;
        end
        chk("stall_resp_seen", 32'(found), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_id", 32'(resp_id), 32'd3);
            chk("stall_prod", resp_prod, 32'h0000FF00);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++)
            do_op(vecs[k].r, vecs[k].x, vecs[k].y, vecs[k].s, vecs[k].exp, $sformatf("vec%0d", k));

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/karatsuba_mul_arbiter.md
Name: karatsuba_mul_arbiter

Overview:
- Shares one combinational karatsuba_16 (16x16 -> 32 unsigned) multiplier among NUM_REQ requesters.
- Round-robin arbitration with valid/ready request and response handshakes.
- The multiplier inputs and output are registered, which breaks the long ripple-carry path into one full cycle.
- Sits between execute-stage clients (MIPS mult/multu unit, address-scaling logic) and the multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept. One-hot or zero.
- req_x  in  16*NUM_REQ  packed multiplicands. Requester i uses [16i+15:16i].
- req_y  in  16*NUM_REQ  packed multipliers, same packing as req_x.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_prod  out  32  product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, MUL, RESP.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - resp_valid=0, resp_id=0, resp_prod=0, busy=0, req_ready=0.
  - Operand registers op_x and op_y are cleared.
  - Reset mid-operation drops the in-flight request. No response is issued for it.
- Arbitration:
  - Combinational grant, one-hot.
  - Picks the first asserted req_valid searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only in IDLE, or in RESP while resp_ready=1, and only when some req_valid is set.
  - A transfer occurs when req_valid[g] && req_ready[g]. On transfer:
    - op_x and op_y latch requester g's operands.
    - id_q latches g.
    - rr_ptr becomes (g+1) mod NUM_REQ.
- IDLE: on a transfer -> MUL, otherwise stay in IDLE.
- MUL (exactly one cycle):
  - prod_q <= karatsuba_16(op_x, op_y).
  - Next state is RESP.
- RESP:
  - resp_valid=1, resp_prod=prod_q, resp_id=id_q.
  - These outputs hold stable while resp_ready=0.
  - resp_ready=1 with a pending request: new transfer in the same cycle, next state MUL (back-to-back issue).
  - resp_ready=1 with no pending request: next state IDLE.
- Timing:
  - Latency is 2 cycles from the accept edge to resp_valid.
  - Peak throughput is one product per 2 cycles.
- Requester rules:
  - Must hold req_x, req_y and req_valid until its ready is seen.
  - Deasserting req_valid before ready is legal. The request is simply not taken.
- Arithmetic:
  - Unsigned. 0xFFFF*0xFFFF = 0xFFFE0001.
  - The product is the full 32 bits, with no truncation.
- Boundaries:
  - No req_valid set: req_ready stays 0 and rr_ptr is unchanged.
  - All requesters valid: grants rotate 0,1,2,3,0...
  - Only one requester valid: it wins every slot regardless of rr_ptr.

Optional Feature:
- Macro: KARATSUBA_MUL_ARBITER_SIGNED_EN.
- With the macro defined:
  - Adds input port req_signed [NUM_REQ-1:0], sampled with the operands at transfer.
  - A signed request treats operands as two's complement. op_x and op_y store magnitudes; -32768 gives magnitude 0x8000, which fits.
  - A sign flag is stored as x_sign ^ y_sign.
  - In MUL, prod_q is negated (invert plus one, using rca_Nbit #(32)) when the sign flag is set.
  - Latency is unchanged.
- Without the macro: the port is absent and all operations are unsigned.

Decomposition:
- Package karatsuba_mul_arbiter_pkg:
  - State enum (IDLE, MUL, RESP).
  - OPW=16 and PRODW=32 constants.
- One sub-module, mul_rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, encoded grant index, any_req.
  - Purely combinational; the FSM owns rr_ptr.
- The multiplier is the existing karatsuba_16, instantiated once.

Test Plan:
- Reset, then requester 2 sends 0x1234*0x5678 -> req_ready[2] at the accept edge; resp_valid 2 cycles later with resp_prod=0x06260060, resp_id=2; busy=1 throughout.
- All 4 requesters valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0; one response every 2 cycles; 0xFFFF*0xFFFF gives 0xFFFE0001.
- resp_ready held 0 for 5 cycles in RESP -> resp_prod and resp_id stable; req_ready all 0; next grant occurs only on the resp_ready=1 cycle.
- rst_n=0 asserted during MUL -> next cycle resp_valid=0, state IDLE, rr_ptr=0; the dropped request yields no response.
- Operand edge cases: 0*0xFFFF=0, 1*0xABCD=0x0000ABCD, 0x8000*0x8000=0x40000000.
- SIGNED_EN: req_signed=1 with 0xFFFF*0x0002 -> 0xFFFFFFFE; 0x8000*0x8000 -> 0x40000000; 0x8000*0x0001 -> 0xFFFF8000; the same operands with req_signed=0 give unsigned results.
